// File: rtl/router_pkg.sv
// Shared constants and helpers for the 1x3 router datapath.
package router_pkg;

    localparam int DATA_WIDTH = 8;
    localparam int ADDR_W     = 2;

    localparam logic [ADDR_W-1:0] ADDR_INVALID = 2'b11;

    // Header layout: low bits are the destination, the rest is payload length.
    localparam int ADDR_LSB = 0;
    localparam int ADDR_MSB = ADDR_W - 1;
    localparam int LEN_LSB  = ADDR_W;
    localparam int LEN_MSB  = DATA_WIDTH - 1;

    // Datapath action chosen for the current cycle from the FSM strobes.
    typedef enum logic [2:0] {
        ACT_NONE,
        ACT_DECODE,
        ACT_LFD,
        ACT_LD,
        ACT_FULL,
        ACT_LAF,
        ACT_CHECK
    } reg_act_e;

    // A destination address is usable unless it is the reserved code.
    function automatic logic addr_valid(input logic [ADDR_W-1:0] addr);
        return addr != ADDR_INVALID;
    endfunction

    // Map the strobes to one action; the FSM guarantees one-hot, the order
    // here only fixes behaviour if that guarantee is ever broken.
    function automatic reg_act_e decode_strobes(
        input logic detect_add,
        input logic lfd_state,
        input logic ld_state,
        input logic full_state,
        input logic laf_state,
        input logic rst_int_reg
    );
        if (detect_add)       return ACT_DECODE;
        else if (lfd_state)   return ACT_LFD;
        else if (ld_state)    return ACT_LD;
        else if (full_state)  return ACT_FULL;
        else if (laf_state)   return ACT_LAF;
        else if (rst_int_reg) return ACT_CHECK;
        else                  return ACT_NONE;
    endfunction

endpackage

// File: rtl/router_parity_acc.sv
// Packet parity accumulator: running XOR of header/payload bytes, the received
// parity byte, and the compare result that becomes err.
module router_parity_acc
    import router_pkg::*;
#(
    parameter int W = DATA_WIDTH
) (
    input  logic         clock,
    input  logic         resetn,
    input  logic         clear,
    input  logic         acc_en,
    input  logic [W-1:0] acc_data,
    input  logic         pkt_load,
    input  logic [W-1:0] pkt_data,
    input  logic         check,
    output logic         err
);

    logic [W-1:0] int_par_reg;
    logic [W-1:0] int_par_next;
    logic [W-1:0] pkt_par_reg;
    logic         err_reg;

    // Per-bit XOR fold of the incoming byte when accumulation is enabled.
    genvar gi;
    generate
        for (gi = 0; gi < W; gi++) begin : g_acc_bit
            assign int_par_next[gi] = acc_en ? (int_par_reg[gi] ^ acc_data[gi])
                                             : int_par_reg[gi];
        end
    endgenerate

    // Parity state: clear wins, otherwise accumulate / load / compare.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            int_par_reg <= '0;
            pkt_par_reg <= '0;
            err_reg     <= 1'b0;
        end else if (clear) begin
            int_par_reg <= '0;
            pkt_par_reg <= '0;
            err_reg     <= 1'b0;
        end else begin
            int_par_reg <= int_par_next;
            if (pkt_load)
                pkt_par_reg <= pkt_data;
            if (check)
                err_reg <= (int_par_reg != pkt_par_reg);
        end
    end

    assign err = err_reg;

endmodule

// File: rtl/router_reg.sv
// Router datapath register stage: header capture, FIFO write byte, full-hold
// buffer, and end-of-packet / parity status back to the FSM.
module router_reg
    import router_pkg::*;
#(
    parameter int DATA_WIDTH = router_pkg::DATA_WIDTH
) (
    input  logic                  clock,
    input  logic                  resetn,
    input  logic                  pkt_vld,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  fifo_full,
    input  logic                  detect_add,
    input  logic                  lfd_state,
    input  logic                  ld_state,
    input  logic                  laf_state,
    input  logic                  full_state,
    input  logic                  rst_int_reg,
    output logic [DATA_WIDTH-1:0] dout,
    output logic                  parity_done,
    output logic                  low_pkt_valid,
    output logic                  err
);

    reg_act_e act;

    logic [DATA_WIDTH-1:0] hdr_reg,  hdr_next;
    logic [DATA_WIDTH-1:0] hold_reg, hold_next;
    logic                  hold_par_reg, hold_par_next;
    logic [DATA_WIDTH-1:0] dout_reg, dout_next;
    logic                  parity_done_reg, parity_done_next;
    logic                  low_pkt_valid_reg, low_pkt_valid_next;

    logic                  par_clear;
    logic                  par_acc_en;
    logic [DATA_WIDTH-1:0] par_acc_data;
    logic                  par_pkt_load;
    logic [DATA_WIDTH-1:0] par_pkt_data;
    logic                  par_check;

    assign act = decode_strobes(detect_add, lfd_state, ld_state,
                                full_state, laf_state, rst_int_reg);

    // Next-state for the datapath registers and parity accumulator controls.
    always_comb begin
        hdr_next           = hdr_reg;
        hold_next          = hold_reg;
        hold_par_next      = hold_par_reg;
        dout_next          = dout_reg;
        parity_done_next   = parity_done_reg;
        low_pkt_valid_next = low_pkt_valid_reg;
        par_clear          = 1'b0;
        par_acc_en         = 1'b0;
        par_acc_data       = '0;
        par_pkt_load       = 1'b0;
        par_pkt_data       = '0;
        par_check          = 1'b0;

        case (act)
            ACT_DECODE: begin
                // Only per-packet clear point; dout keeps the last byte.
                par_clear        = 1'b1;
                parity_done_next = 1'b0;
                if (pkt_vld && addr_valid(data_in[ADDR_MSB:ADDR_LSB]))
                    hdr_next = data_in;
            end
            ACT_LFD: begin
                dout_next    = hdr_reg;
                par_acc_en   = 1'b1;
                par_acc_data = hdr_reg;
            end
            ACT_LD: begin
                if (!fifo_full) begin
                    dout_next = data_in;
                    if (pkt_vld) begin
                        par_acc_en   = 1'b1;
                        par_acc_data = data_in;
                    end else begin
                        par_pkt_load     = 1'b1;
                        par_pkt_data     = data_in;
                        parity_done_next = 1'b1;
                    end
                end else begin
                    // Park the byte; it is replayed (and counted) in LAF.
                    hold_next     = data_in;
                    hold_par_next = ~pkt_vld;
                end
                if (!pkt_vld)
                    low_pkt_valid_next = 1'b1;
            end
            ACT_LAF: begin
                dout_next = hold_reg;
                if (hold_par_reg) begin
                    par_pkt_load     = 1'b1;
                    par_pkt_data     = hold_reg;
                    parity_done_next = 1'b1;
                end else begin
                    par_acc_en   = 1'b1;
                    par_acc_data = hold_reg;
                end
            end
            ACT_CHECK: begin
                par_check          = 1'b1;
                low_pkt_valid_next = 1'b0;
            end
            default: begin
                // FIFO_FULL and idle states leave everything untouched.
            end
        endcase
    end

    // Datapath register bank.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            hdr_reg           <= '0;
            hold_reg          <= '0;
            hold_par_reg      <= 1'b0;
            dout_reg          <= '0;
            parity_done_reg   <= 1'b0;
            low_pkt_valid_reg <= 1'b0;
        end else begin
            hdr_reg           <= hdr_next;
            hold_reg          <= hold_next;
            hold_par_reg      <= hold_par_next;
            dout_reg          <= dout_next;
            parity_done_reg   <= parity_done_next;
            low_pkt_valid_reg <= low_pkt_valid_next;
        end
    end

    router_parity_acc #(
        .W (DATA_WIDTH)
    ) u_parity (
        .clock    (clock),
        .resetn   (resetn),
        .clear    (par_clear),
        .acc_en   (par_acc_en),
        .acc_data (par_acc_data),
        .pkt_load (par_pkt_load),
        .pkt_data (par_pkt_data),
        .check    (par_check),
        .err      (err)
    );

    assign dout          = dout_reg;
    assign parity_done   = parity_done_reg;
    assign low_pkt_valid = low_pkt_valid_reg;

endmodule

// File: tb/tb_router_reg.sv
// Scenario bench for router_reg: the FSM strobes are driven directly, every
// byte expected on dout is queued when driven and checked after the edge.
module tb_router_reg;
    import router_pkg::*;

    logic                  clock = 1'b0;
    logic                  resetn;
    logic                  pkt_vld;
    logic [DATA_WIDTH-1:0] data_in;
    logic                  fifo_full;
    logic                  detect_add, lfd_state, ld_state, laf_state, full_state, rst_int_reg;
    logic [DATA_WIDTH-1:0] dout;
    logic                  parity_done, low_pkt_valid, err;

    int total = 0;
    int bad   = 0;
    int txn   = 0;
    logic [DATA_WIDTH-1:0] sb[$];

    typedef enum {S_NONE, S_DEC, S_LFD, S_LD, S_FULL, S_LAF, S_RST} st_e;

    always #5 clock = ~clock;

    router_reg #(.DATA_WIDTH(DATA_WIDTH)) dut (
        .clock         (clock),
        .resetn        (resetn),
        .pkt_vld       (pkt_vld),
        .data_in       (data_in),
        .fifo_full     (fifo_full),
        .detect_add    (detect_add),
        .lfd_state     (lfd_state),
        .ld_state      (ld_state),
        .laf_state     (laf_state),
        .full_state    (full_state),
        .rst_int_reg   (rst_int_reg),
        .dout          (dout),
        .parity_done   (parity_done),
        .low_pkt_valid (low_pkt_valid),
        .err           (err)
    );

    // The strobes model a one-hot FSM.
    always @(posedge clock)
        if (resetn)
            assert ($onehot0({detect_add, lfd_state, ld_state, laf_state, full_state, rst_int_reg}))
                else $error("strobes not one-hot");

    // One FSM cycle; a queued byte is compared against dout after the edge.
    task automatic tick(input st_e s, input logic vld, input logic [7:0] d,
                        input logic full, input bit push, input logic [7:0] expd);
        logic [7:0] e;
        detect_add  = (s == S_DEC);
        lfd_state   = (s == S_LFD);
        ld_state    = (s == S_LD);
        full_state  = (s == S_FULL);
        laf_state   = (s == S_LAF);
        rst_int_reg = (s == S_RST);
        pkt_vld     = vld;
        data_in     = d;
        fifo_full   = full;
        if (push) sb.push_back(expd);
        @(posedge clock);
        #1;
        if (push) begin
            e = sb.pop_front();
            txn++;
            total++;
            $display("txn %0d state=%s dout=%h expect=%h", txn, s.name(), dout, e);
            if (dout !== e) begin
                bad++;
                $display("FAIL sb_dout txn %0d got=%h want=%h", txn, dout, e);
            end
        end
    endtask

    // Header 0D, payload 11/22/33, then the parity byte; FIFO never full.
    task automatic pkt_body(input logic [7:0] par);
        tick(S_DEC, 1'b1, 8'h0D, 1'b0, 1'b0, 8'h00);
        tick(S_LFD, 1'b1, 8'h11, 1'b0, 1'b1, 8'h0D);
        tick(S_LD,  1'b1, 8'h11, 1'b0, 1'b1, 8'h11);
        tick(S_LD,  1'b1, 8'h22, 1'b0, 1'b1, 8'h22);
        tick(S_LD,  1'b1, 8'h33, 1'b0, 1'b1, 8'h33);
        tick(S_LD,  1'b0, par,   1'b0, 1'b1, par);
    endtask

    task automatic test_reset();
        resetn = 1'b1;
        pkt_vld = 1'b0; data_in = '0; fifo_full = 1'b0;
        detect_add = 1'b0; lfd_state = 1'b0; ld_state = 1'b0;
        laf_state = 1'b0; full_state = 1'b0; rst_int_reg = 1'b0;
        #1 resetn = 1'b0;
        #2;
        total++; if (dout !== 8'h00) begin bad++; $display("FAIL reset_dout got=%h want=00", dout); end
        total++; if (parity_done !== 1'b0) begin bad++; $display("FAIL reset_parity_done got=%b want=0", parity_done); end
        total++; if (low_pkt_valid !== 1'b0) begin bad++; $display("FAIL reset_low_pkt_valid got=%b want=0", low_pkt_valid); end
        total++; if (err !== 1'b0) begin bad++; $display("FAIL reset_err got=%b want=0", err); end
        @(posedge clock); @(posedge clock); #1;
        resetn = 1'b1;
    endtask

    // Starts from dout=00 (just after a reset).
    task automatic test_good_packet();
        tick(S_DEC, 1'b1, 8'h0D, 1'b0, 1'b0, 8'h00);
        total++; if (dout !== 8'h00) begin bad++; $display("FAIL good_dec_dout got=%h want=00", dout); end
        tick(S_LFD, 1'b1, 8'h11, 1'b0, 1'b1, 8'h0D);
        tick(S_LD,  1'b1, 8'h11, 1'b0, 1'b1, 8'h11);
        tick(S_LD,  1'b1, 8'h22, 1'b0, 1'b1, 8'h22);
        total++; if (parity_done !== 1'b0) begin bad++; $display("FAIL good_pd_early got=%b want=0", parity_done); end
        tick(S_LD,  1'b1, 8'h33, 1'b0, 1'b1, 8'h33);
        tick(S_LD,  1'b0, 8'h0D, 1'b0, 1'b1, 8'h0D);
        total++; if (parity_done !== 1'b1) begin bad++; $display("FAIL good_parity_done got=%b want=1", parity_done); end
        total++; if (low_pkt_valid !== 1'b1) begin bad++; $display("FAIL good_low_pkt_valid got=%b want=1", low_pkt_valid); end
        tick(S_NONE, 1'b0, 8'h0D, 1'b0, 1'b0, 8'h00);
        tick(S_RST,  1'b0, 8'h0D, 1'b0, 1'b0, 8'h00);
        total++; if (err !== 1'b0) begin bad++; $display("FAIL good_err got=%b want=0", err); end
        total++; if (low_pkt_valid !== 1'b0) begin bad++; $display("FAIL good_lpv_clear got=%b want=0", low_pkt_valid); end
    endtask

    task automatic test_bad_parity();
        pkt_body(8'h0C);
        tick(S_NONE, 1'b0, 8'h0C, 1'b0, 1'b0, 8'h00);
        total++; if (err !== 1'b0) begin bad++; $display("FAIL bad_err_early got=%b want=0", err); end
        tick(S_RST,  1'b0, 8'h0C, 1'b0, 1'b0, 8'h00);
        total++; if (err !== 1'b1) begin bad++; $display("FAIL bad_err got=%b want=1", err); end
        tick(S_NONE, 1'b0, 8'h0C, 1'b0, 1'b0, 8'h00);
        total++; if (err !== 1'b1) begin bad++; $display("FAIL bad_err_hold got=%b want=1", err); end
        tick(S_DEC,  1'b0, 8'h00, 1'b0, 1'b0, 8'h00);
        total++; if (err !== 1'b0) begin bad++; $display("FAIL bad_err_clear got=%b want=0", err); end
    endtask

    // dout is 0C from the previous packet's parity; header 0D is still stored.
    task automatic test_invalid_addr();
        tick(S_DEC, 1'b1, 8'h0F, 1'b0, 1'b0, 8'h00);
        total++; if (dout !== 8'h0C) begin bad++; $display("FAIL inv_dout_hold got=%h want=0C", dout); end
        tick(S_LFD, 1'b1, 8'h11, 1'b0, 1'b1, 8'h0D);
    endtask

    task automatic test_full_payload();
        tick(S_DEC, 1'b1, 8'h0D, 1'b0, 1'b0, 8'h00);
        tick(S_LFD, 1'b1, 8'h11, 1'b0, 1'b1, 8'h0D);
        tick(S_LD,  1'b1, 8'h11, 1'b0, 1'b1, 8'h11);
        tick(S_LD,  1'b1, 8'h22, 1'b1, 1'b0, 8'h00);
        total++; if (dout !== 8'h11) begin bad++; $display("FAIL fp_dout_hold got=%h want=11", dout); end
        tick(S_FULL, 1'b1, 8'h33, 1'b1, 1'b0, 8'h00);
        total++; if (dout !== 8'h11) begin bad++; $display("FAIL fp_dout_full got=%h want=11", dout); end
        tick(S_LAF, 1'b1, 8'h33, 1'b0, 1'b1, 8'h22);
        total++; if (parity_done !== 1'b0) begin bad++; $display("FAIL fp_pd got=%b want=0", parity_done); end
        tick(S_LD,  1'b1, 8'h33, 1'b0, 1'b1, 8'h33);
        tick(S_LD,  1'b0, 8'h0D, 1'b0, 1'b1, 8'h0D);
        tick(S_NONE, 1'b0, 8'h0D, 1'b0, 1'b0, 8'h00);
        tick(S_RST,  1'b0, 8'h0D, 1'b0, 1'b0, 8'h00);
        total++; if (err !== 1'b0) begin bad++; $display("FAIL fp_err got=%b want=0", err); end
    endtask

    task automatic test_full_parity();
        tick(S_DEC, 1'b1, 8'h0D, 1'b0, 1'b0, 8'h00);
        tick(S_LFD, 1'b1, 8'h11, 1'b0, 1'b1, 8'h0D);
        tick(S_LD,  1'b1, 8'h11, 1'b0, 1'b1, 8'h11);
        tick(S_LD,  1'b1, 8'h22, 1'b0, 1'b1, 8'h22);
        tick(S_LD,  1'b1, 8'h33, 1'b0, 1'b1, 8'h33);
        tick(S_LD,  1'b0, 8'h0D, 1'b1, 1'b0, 8'h00);
        total++; if (low_pkt_valid !== 1'b1) begin bad++; $display("FAIL fpar_lpv got=%b want=1", low_pkt_valid); end
        total++; if (parity_done !== 1'b0) begin bad++; $display("FAIL fpar_pd_ld got=%b want=0", parity_done); end
        total++; if (dout !== 8'h33) begin bad++; $display("FAIL fpar_dout_hold got=%h want=33", dout); end
        tick(S_FULL, 1'b0, 8'h0D, 1'b1, 1'b0, 8'h00);
        total++; if (parity_done !== 1'b0) begin bad++; $display("FAIL fpar_pd_full got=%b want=0", parity_done); end
        total++; if (low_pkt_valid !== 1'b1) begin bad++; $display("FAIL fpar_lpv_full got=%b want=1", low_pkt_valid); end
        tick(S_LAF, 1'b0, 8'h0D, 1'b0, 1'b1, 8'h0D);
        total++; if (parity_done !== 1'b1) begin bad++; $display("FAIL fpar_pd_laf got=%b want=1", parity_done); end
        total++; if (low_pkt_valid !== 1'b1) begin bad++; $display("FAIL fpar_lpv_laf got=%b want=1", low_pkt_valid); end
        tick(S_NONE, 1'b0, 8'h0D, 1'b0, 1'b0, 8'h00);
        tick(S_RST,  1'b0, 8'h0D, 1'b0, 1'b0, 8'h00);
        total++; if (err !== 1'b0) begin bad++; $display("FAIL fpar_err got=%b want=0", err); end
    endtask

    task automatic test_reset_mid();
        tick(S_DEC, 1'b1, 8'h0D, 1'b0, 1'b0, 8'h00);
        tick(S_LFD, 1'b1, 8'h11, 1'b0, 1'b1, 8'h0D);
        tick(S_LD,  1'b1, 8'h11, 1'b0, 1'b1, 8'h11);
        tick(S_LD,  1'b0, 8'h5A, 1'b0, 1'b1, 8'h5A);
        resetn = 1'b0;
        #1;
        total++; if (dout !== 8'h00) begin bad++; $display("FAIL mid_dout got=%h want=00", dout); end
        total++; if (parity_done !== 1'b0) begin bad++; $display("FAIL mid_parity_done got=%b want=0", parity_done); end
        total++; if (low_pkt_valid !== 1'b0) begin bad++; $display("FAIL mid_low_pkt_valid got=%b want=0", low_pkt_valid); end
        total++; if (err !== 1'b0) begin bad++; $display("FAIL mid_err got=%b want=0", err); end
        ld_state = 1'b0;
        @(posedge clock); #1;
        resetn = 1'b1;
        test_good_packet();
    endtask

    initial begin
        test_reset();
        test_good_packet();
        test_bad_parity();
        test_invalid_addr();
        test_full_payload();
        test_full_parity();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/router_reg.md
# router_reg

Datapath register stage of the 1x3 router, driven by the router FSM's state strobes. Captures the header byte, streams payload and parity bytes to the FIFO write bus (`dout`), and holds the byte that arrives while the destination FIFO is full. Accumulates packet parity and reports `parity_done`, `low_pkt_valid` and `err` back to the FSM and the top level.

## Interface
- `DATA_WIDTH`, 8: byte width of `data_in` and `dout`.
- `clock` input 1: single clock, rising edge.
- `resetn` input 1: asynchronous, active-low reset.
- `pkt_vld` input 1: source packet valid. High for header and payload bytes; low on the parity byte.
- `data_in` input DATA_WIDTH: source byte. Header format: [DATA_WIDTH-1:2] is the payload length and [1:0] is the destination address (2'b11 is invalid).
- `fifo_full` input 1: the selected destination FIFO is full.
- `detect_add`, `lfd_state`, `ld_state`, `laf_state`, `full_state`, `rst_int_reg` input 1 each: one-hot FSM state strobes.
- `dout` output DATA_WIDTH: byte presented to the FIFO write port.
- `parity_done` output 1: the parity byte has been loaded to `dout`.
- `low_pkt_valid` output 1: `pkt_vld` fell during LOAD_DATA (end of packet seen).
- `err` output 1: the received parity does not match the computed parity.

## Operation
- All state is registered. Reset value of every output and internal register is 0.
- Internal registers:
  - `hdr`: header byte.
  - `hold`: byte captured while the FIFO is full.
  - `hold_par`: the held byte is the parity byte.
  - `int_par`: running XOR.
  - `pkt_par`: received parity.
- Evaluation priority within one cycle is the order listed below.
- DECODE (`detect_add`):
  - Clear `int_par`, `pkt_par`, `parity_done`, `err`. This is the only per-packet clear; soft resets reach this block only as a return to DECODE.
  - If `pkt_vld` and `data_in[1:0]`≠2'b11, load `hdr` <= `data_in`. `dout` holds.
- LOAD_FIRST_DATA (`lfd_state`): `dout` <= `hdr` and `int_par` ^= `hdr`.
- LOAD_DATA (`ld_state`):
  - Not full, `pkt_vld`=1: `dout` <= `data_in` and `int_par` ^= `data_in`.
  - Not full, `pkt_vld`=0: `dout` <= `data_in`, `pkt_par` <= `data_in`, `parity_done` <= 1.
  - Full: `hold` <= `data_in`, `hold_par` <= ~`pkt_vld`. `dout` holds and parity is untouched.
  - Any `ld_state` with `pkt_vld`=0: `low_pkt_valid` <= 1.
- FIFO_FULL (`full_state`): no register changes.
- LOAD_AFTER_FULL (`laf_state`):
  - `dout` <= `hold`.
  - If `hold_par`=1: `pkt_par` <= `hold` and `parity_done` <= 1.
  - Otherwise: `int_par` ^= `hold`.
- CHECK_PARITY (`rst_int_reg`): `err` <= (`int_par` ≠ `pkt_par`) and `low_pkt_valid` <= 0.
- Every byte goes into `int_par` exactly once. Bytes on `data_in` outside `ld_state` (source stalled on busy) are ignored.

## Timing
- Latency: `data_in` to `dout` is one cycle, registered on the edge that ends the sampling state.
- `parity_done` rises one cycle after the parity byte is sampled. This makes it visible in the FSM's following state: LOAD_PARITY, or LAF→LOAD_PARITY on the full path.
- `err` is valid from the cycle after `rst_int_reg` and is held until the next `detect_add`.
- Overlapping strobes are an FSM fault and need not be handled. The bench asserts one-hot.
- Async reset mid-packet forces all outputs to 0 immediately. The next packet starts clean at DECODE.
- `low_pkt_valid` stays high through FIFO_FULL and LAF until `rst_int_reg`.

## Structure
- Shared package `router_pkg`: `DATA_WIDTH`, `ADDR_W`=2, `ADDR_INVALID`=2'b11, header field slice constants.
- Optional sub-module `router_parity_acc`: XOR accumulator with clear, enable and compare; it owns `int_par`, `pkt_par` and `err`. All other logic stays flat.

## Test plan
- Header 8'h0D (len 3, addr 1), payload 11/22/33, parity 8'h0D, FIFO never full → `dout` sequence 0D,11,22,33,0D. `parity_done`=1 after the parity sample. `err`=0 after `rst_int_reg`.
- Same packet with parity 8'h0C → `err`=1 one cycle after `rst_int_reg`. `err` clears on the next `detect_add`.
- `fifo_full`=1 while payload 22 is sampled in `ld_state` → `dout` holds 11. After FULL→LAF, `dout`=22. Final `err`=0, so 22 is counted once.
- `fifo_full`=1 while the parity byte is sampled → `low_pkt_valid`=1 and `parity_done`=0 through FULL. In LAF, `dout`=parity and `parity_done` rises.
- Header 8'h0F (addr 3) in DECODE → `hdr` unchanged (previous 8'h0D) and `dout` unchanged.
- `resetn` pulsed low while in LOAD_DATA → `dout`, `parity_done`, `low_pkt_valid`, `err` all 0 immediately. The next good packet passes with `err`=0.
